// File: rtl/ram_sp_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_sp_arb2                                                     |
// | Purpose  : two-port round-robin arbiter/sequencer for one single-port,     |
// |            bit-enable RAM; optional zero-fill engine (RAM_SP_ARB2_INIT_EN) |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ram_sp_arb2 #(
   parameter int CAddrLen = 8,
   parameter int CDataLen = 16
) (
   input  logic                AClkH,
   input  logic                AReset,
   input  logic                AClkHEn,
   input  logic [CAddrLen-1:0] AAddr0,
   input  logic [CDataLen-1:0] AMosi0,
   input  logic [CDataLen-1:0] AWrEn0,
   input  logic                ARdEn0,
   input  logic [CAddrLen-1:0] AAddr1,
   input  logic [CDataLen-1:0] AMosi1,
   input  logic [CDataLen-1:0] AWrEn1,
   input  logic                ARdEn1,
   output logic                AAck0,
   output logic                AAck1,
   output logic [CDataLen-1:0] AMiso0,
   output logic [CDataLen-1:0] AMiso1,
   output logic                AVld0,
   output logic                AVld1,
   output logic                ABusy,
   output logic [CAddrLen-1:0] ARamAddr,
   output logic [CDataLen-1:0] ARamMosi,
   output logic [CDataLen-1:0] ARamWrEn,
   input  logic [CDataLen-1:0] ARamMiso
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

`ifdef RAM_SP_ARB2_INIT_EN
   localparam state_t              c_stReset = ST_INIT;
   localparam logic [CAddrLen-1:0] c_cntOne  = {{(CAddrLen-1){1'b0}}, 1'b1};
`else
   localparam state_t              c_stReset = ST_RUN;
`endif

   state_t r_state;
   state_t w_stateNext;
   logic   r_last;
   logic   r_vld0;
   logic   r_vld1;
   logic   w_req0;
   logic   w_req1;
   logic   w_canGrant;
   logic   w_gnt0;
   logic   w_gnt1;

   assign w_req0     = ARdEn0 | (|AWrEn0);
   assign w_req1     = ARdEn1 | (|AWrEn1);
   assign w_canGrant = AClkHEn & ~AReset & (r_state == ST_RUN);

   // On a tie the port that was not granted last wins.
   assign w_gnt0 = w_canGrant & w_req0 & (~w_req1 | r_last);
   assign w_gnt1 = w_canGrant & w_req1 & (~w_req0 | ~r_last);

   assign AAck0 = w_gnt0;
   assign AAck1 = w_gnt1;

`ifdef RAM_SP_ARB2_INIT_EN
   logic [CAddrLen-1:0] r_initCnt;
   logic                w_initWr;

   assign w_initWr = AClkHEn & ~AReset & (r_state == ST_INIT);
   assign ABusy    = (r_state == ST_INIT);
`else
   assign ABusy    = 1'b0;
`endif

   always_comb begin
      ARamAddr = AAddr0;
      ARamMosi = AMosi0;
      ARamWrEn = '0;
      if (w_gnt1) begin
         ARamAddr = AAddr1;
         ARamMosi = AMosi1;
         ARamWrEn = AWrEn1;
      end else if (w_gnt0) begin
         ARamWrEn = AWrEn0;
      end
`ifdef RAM_SP_ARB2_INIT_EN
      if (w_initWr) begin
         ARamAddr = r_initCnt;
         ARamMosi = '0;
         ARamWrEn = '1;
      end
`endif
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_INIT: begin
`ifdef RAM_SP_ARB2_INIT_EN
            if (w_initWr && (r_initCnt == {CAddrLen{1'b1}})) begin
               w_stateNext = ST_RUN;
            end
`else
            w_stateNext = ST_RUN;
`endif
         end
         ST_RUN:  w_stateNext = ST_RUN;
         default: w_stateNext = ST_RUN;
      endcase
   end

   always_ff @(posedge AClkH) begin
      if (AReset) begin
         r_state <= c_stReset;
         r_last  <= 1'b1;
         r_vld0  <= 1'b0;
         r_vld1  <= 1'b0;
`ifdef RAM_SP_ARB2_INIT_EN
         r_initCnt <= '0;
`endif
      end else if (AClkHEn) begin
         r_state <= w_stateNext;
         if (w_gnt0 | w_gnt1) begin
            r_last <= w_gnt1;
         end
         r_vld0 <= w_gnt0 & ARdEn0;
         r_vld1 <= w_gnt1 & ARdEn1;
`ifdef RAM_SP_ARB2_INIT_EN
         if (r_state == ST_INIT) begin
            r_initCnt <= r_initCnt + c_cntOne;
         end
`endif
      end
   end

   // A read in flight when reset arrives is dropped immediately.
   assign AVld0  = r_vld0 & ~AReset;
   assign AVld1  = r_vld1 & ~AReset;
   assign AMiso0 = AVld0 ? ARamMiso : '0;
   assign AMiso1 = AVld1 ? ARamMiso : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_sp_arb2                                                  |
// | Purpose  : self-checking bench for ram_sp_arb2 with a behavioural RAM      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ram_sp_arb2;

   typedef struct {
      logic        rst;
      logic        en;
      logic        rd0;
      logic [15:0] wr0;
      logic [7:0]  a0;
      logic [15:0] d0;
      logic        rd1;
      logic [15:0] wr1;
      logic [7:0]  a1;
      logic [15:0] d1;
      logic        ack0;
      logic        ack1;
   } vec_t;

   typedef struct {
      int          port;
      logic [15:0] data;
   } sb_t;

`ifdef RAM_SP_ARB2_INIT_EN
   localparam logic [15:0] cFill = 16'hDEAD;
`else
   localparam logic [15:0] cFill = 16'h0000;
`endif

   logic        AClkH = 1'b0;
   logic        AReset, AClkHEn;
   logic [7:0]  AAddr0, AAddr1;
   logic [15:0] AMosi0, AMosi1, AWrEn0, AWrEn1;
   logic        ARdEn0, ARdEn1;
   logic        AAck0, AAck1, AVld0, AVld1, ABusy;
   logic [15:0] AMiso0, AMiso1;
   logic [7:0]  ARamAddr;
   logic [15:0] ARamMosi, ARamWrEn, ARamMiso;

   logic [15:0] ramMem [256] = '{default: cFill};
   logic [7:0]  ramAddrQ = 8'h00;
   logic [15:0] shadow [256] = '{default: 16'h0000};
   sb_t         sb[$];
   vec_t        tbl[$];
   int          nChecks = 0;
   int          nPass   = 0;

   always #5 AClkH = ~AClkH;

   ram_sp_arb2 #(.CAddrLen(8), .CDataLen(16)) dut (
      .AClkH(AClkH), .AReset(AReset), .AClkHEn(AClkHEn),
      .AAddr0(AAddr0), .AMosi0(AMosi0), .AWrEn0(AWrEn0), .ARdEn0(ARdEn0),
      .AAddr1(AAddr1), .AMosi1(AMosi1), .AWrEn1(AWrEn1), .ARdEn1(ARdEn1),
      .AAck0(AAck0), .AAck1(AAck1), .AMiso0(AMiso0), .AMiso1(AMiso1),
      .AVld0(AVld0), .AVld1(AVld1), .ABusy(ABusy),
      .ARamAddr(ARamAddr), .ARamMosi(ARamMosi), .ARamWrEn(ARamWrEn),
      .ARamMiso(ARamMiso)
   );

   // Single-port RAM: registered address/data/enables, unregistered q.
   always @(posedge AClkH) begin
      if (AClkHEn) begin
         ramMem[ARamAddr] <= (ramMem[ARamAddr] & ~ARamWrEn) | (ARamMosi & ARamWrEn);
         ramAddrQ         <= ARamAddr;
      end
   end
   assign ARamMiso = ramMem[ramAddrQ];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         nPass++;
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic en,
                               input logic rd0, input logic [15:0] wr0,
                               input logic [7:0] a0, input logic [15:0] d0,
                               input logic rd1, input logic [15:0] wr1,
                               input logic [7:0] a1, input logic [15:0] d1,
                               input logic ack0, input logic ack1);
      vec_t v;
      v.rst = rst; v.en = en;
      v.rd0 = rd0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0;
      v.rd1 = rd1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1;
      v.ack0 = ack0; v.ack1 = ack1;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      AReset = v.rst; AClkHEn = v.en;
      ARdEn0 = v.rd0; AWrEn0 = v.wr0; AAddr0 = v.a0; AMosi0 = v.d0;
      ARdEn1 = v.rd1; AWrEn1 = v.wr1; AAddr1 = v.a1; AMosi1 = v.d1;
   endtask

   // One clock: drive, check mid-cycle, then advance the reference model.
   task automatic step(input int idx, input vec_t v);
      logic        ev0, ev1;
      logic [15:0] ed, ewr;
      @(posedge AClkH); #1;
      drive(v);
      @(negedge AClkH);
      ev0 = 1'b0; ev1 = 1'b0; ed = 16'h0;
      if (!v.rst && sb.size() > 0) begin
         ev0 = (sb[0].port == 0);
         ev1 = (sb[0].port == 1);
         ed  = sb[0].data;
      end
      ewr = v.ack0 ? v.wr0 : (v.ack1 ? v.wr1 : 16'h0);
      check($sformatf("ack0[%0d]", idx), {31'd0, AAck0}, {31'd0, v.ack0});
      check($sformatf("ack1[%0d]", idx), {31'd0, AAck1}, {31'd0, v.ack1});
      check($sformatf("vld0[%0d]", idx), {31'd0, AVld0}, {31'd0, ev0});
      check($sformatf("vld1[%0d]", idx), {31'd0, AVld1}, {31'd0, ev1});
      check($sformatf("miso0[%0d]", idx), {16'd0, AMiso0}, {16'd0, ev0 ? ed : 16'h0});
      check($sformatf("miso1[%0d]", idx), {16'd0, AMiso1}, {16'd0, ev1 ? ed : 16'h0});
      check($sformatf("ramwren[%0d]", idx), {16'd0, ARamWrEn}, {16'd0, ewr});
      if (v.rst) begin
         sb.delete();
      end else if (v.en) begin
         if (sb.size() > 0) void'(sb.pop_front());
         if (v.ack0) begin
            shadow[v.a0] = (shadow[v.a0] & ~v.wr0) | (v.d0 & v.wr0);
            if (v.rd0) sb.push_back('{0, shadow[v.a0]});
         end
         if (v.ack1) begin
            shadow[v.a1] = (shadow[v.a1] & ~v.wr1) | (v.d1 & v.wr1);
            if (v.rd1) sb.push_back('{1, shadow[v.a1]});
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t idle;
      int   busyCnt;
      int   ackWhileBusy;
      logic seen;

      idle = mk(0, 1, 0, 16'h0, 8'h00, 16'h0, 0, 16'h0, 8'h00, 16'h0, 0, 0);

      // Reset with both ports requesting: nothing may be granted.
      step(-2, mk(1, 1, 1, 16'h0, 8'h00, 16'h0, 1, 16'hFFFF, 8'h01, 16'h5555, 0, 0));
      step(-1, mk(1, 1, 1, 16'h0, 8'h00, 16'h0, 1, 16'hFFFF, 8'h01, 16'h5555, 0, 0));

`ifdef RAM_SP_ARB2_INIT_EN
      @(posedge AClkH); #1;
      drive(mk(0, 1, 0, 16'h0, 8'h00, 16'h0, 1, 16'h0, 8'h77, 16'h0, 0, 0));
      busyCnt = 0; ackWhileBusy = 0; seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge AClkH);
         if (ABusy) begin
            busyCnt++;
            if (AAck0 || AAck1) ackWhileBusy++;
         end else begin
            seen = 1'b1;
         end
      end
      check("init_done", {31'd0, seen}, 32'd1);
      check("init_cycles", busyCnt, 256);
      check("init_no_ack", ackWhileBusy, 0);
      check("init_first_ack1", {31'd0, AAck1}, 32'd1);
      @(posedge AClkH); #1;
      drive(idle);
      @(negedge AClkH);
      check("init_vld1", {31'd0, AVld1}, 32'd1);
      check("init_zero", {16'd0, AMiso1}, 32'd0);
`else
      check("busy_rst", {31'd0, ABusy}, 32'd0);
`endif

      // Single write then readback, partial mask, alternation, clock-enable hold.
      tbl.push_back(mk(0, 1, 0, 16'hFFFF, 8'hA5, 16'h0012, 0, 16'h0, 8'h00, 16'h0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 16'h0000, 8'hA5, 16'h0000, 0, 16'h0, 8'h00, 16'h0, 1, 0));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 1, 0, 16'h0, 8'h00, 16'h0, 0, 16'hFFFF, 8'h10, 16'h1234, 0, 1));
      tbl.push_back(mk(0, 1, 0, 16'h0, 8'h00, 16'h0, 0, 16'h00FF, 8'h10, 16'hBEEF, 0, 1));
      tbl.push_back(mk(0, 1, 0, 16'h0, 8'h00, 16'h0, 1, 16'h0000, 8'h10, 16'h0000, 0, 1));
      tbl.push_back(idle);
      for (int i = 0; i < 6; i++) begin
         tbl.push_back(mk(0, 1, 1, 16'h0, 8'hA5, 16'h0, 1, 16'h0, 8'h10, 16'h0,
                          (i % 2) == 0, (i % 2) == 1));
      end
      for (int i = 0; i < 3; i++) begin
         tbl.push_back(mk(0, 0, 1, 16'h0, 8'hA5, 16'h0, 1, 16'h0, 8'h10, 16'h0, 0, 0));
      end
      tbl.push_back(mk(0, 1, 1, 16'h0, 8'hA5, 16'h0, 1, 16'h0, 8'h10, 16'h0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 16'h0, 8'hA5, 16'h0, 1, 16'h0, 8'h10, 16'h0, 0, 1));
      tbl.push_back(idle);
      // Read+write in one request, then a masked write racing a read.
      tbl.push_back(mk(0, 1, 1, 16'hFFFF, 8'h33, 16'hA5A5, 0, 16'h0, 8'h00, 16'h0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 16'hF000, 8'h33, 16'h0000, 1, 16'h0, 8'h33, 16'h0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 16'hF000, 8'h33, 16'h0000, 0, 16'h0, 8'h00, 16'h0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 16'h0, 8'h00, 16'h0, 1, 16'h0, 8'h33, 16'h0, 0, 1));
      tbl.push_back(idle);

      foreach (tbl[i]) step(i, tbl[i]);

      // Reset lands the cycle after a read grant: the read is dropped and
      // the arbiter forgets that port 0 was granted last.
      step(100, mk(0, 1, 1, 16'h0, 8'hA5, 16'h0, 0, 16'h0, 8'h00, 16'h0, 1, 0));
      step(101, mk(1, 1, 1, 16'h0, 8'hA5, 16'h0, 1, 16'h0, 8'h10, 16'h0, 0, 0));
`ifdef RAM_SP_ARB2_INIT_EN
      @(posedge AClkH); #1;
      drive(mk(0, 1, 1, 16'h0, 8'hA5, 16'h0, 1, 16'h0, 8'h10, 16'h0, 0, 0));
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge AClkH);
         if (!ABusy) seen = 1'b1;
      end
      check("reinit_done", {31'd0, seen}, 32'd1);
      check("rst_tie_ack0", {31'd0, AAck0}, 32'd1);
      check("rst_tie_ack1", {31'd0, AAck1}, 32'd0);
`else
      step(102, mk(0, 1, 1, 16'h0, 8'hA5, 16'h0, 1, 16'h0, 8'h10, 16'h0, 1, 0));
      step(103, idle);
`endif

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
